// File: rtl/chs_pkg.sv
// chs_pkg: shared state codes, chs_conf saturation limits and default timing constants
package chs_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HEAT   = 3'd1,
        ST_COOL   = 3'd2,
        ST_RAMPDN = 3'd3,
        ST_DEAD   = 3'd4
    } chs_state_e;

    localparam logic signed [8:0] CONF_MAX = 9'sd127;
    localparam logic signed [8:0] CONF_MIN = -9'sd128;

    localparam int TICK_DIV_DEF = 1000;
    localparam int HYST_DEF     = 2;
    localparam int MIN_ON_DEF   = 16;
    localparam int DEAD_DEF     = 8;
    localparam int FAN_STEP_DEF = 8;
    localparam int FAN_MAX_DEF  = 255;

    // clamp the 9-bit error into the 8-bit two's complement degree request
    function automatic logic [7:0] sat_conf(input logic signed [8:0] e);
        return e > CONF_MAX ? CONF_MAX[7:0] : e < CONF_MIN ? CONF_MIN[7:0] : e[7:0];
    endfunction

endpackage

// File: rtl/chs_tick_gen.sv
// chs_tick_gen: free-running prescaler emitting a one-cycle tick every TICK_DIV clocks
module chs_tick_gen
    import chs_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEF
) (
    input  logic clk,
    input  logic arst,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0] cnt_q, cnt_d;

    // tick fires on the last count of each period, then the counter wraps
    always_comb begin
        tick  = cnt_q == CW'(TICK_DIV - 1);
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    // prescaler register, cleared asynchronously
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/chs_sequencer.sv
// chs_sequencer: hysteresis thermostat FSM with min on-time, fan ramps and reversal dead time
module chs_sequencer
    import chs_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEF,
    parameter int HYST     = HYST_DEF,
    parameter int MIN_ON   = MIN_ON_DEF,
    parameter int DEAD     = DEAD_DEF,
    parameter int FAN_STEP = FAN_STEP_DEF,
    parameter int FAN_MAX  = FAN_MAX_DEF
) (
    input  logic       clk,
    input  logic       arst,
    input  logic       enable,
    input  logic [7:0] temp_in,
    input  logic [7:0] setpoint,
    output logic [7:0] chs_conf,
    output logic [7:0] speed,
    output logic       heat_req,
    output logic       busy,
    output logic [2:0] state_o
);

    localparam logic signed [8:0] HYST_S = 9'(HYST);

    logic              tick;
    logic signed [8:0] err;
    logic [8:0]        fan_sum;
    logic [7:0]        fan_up, fan_dn, dead_nx;
    logic              crossed;

    chs_state_e        st_q, st_d;
    logic [7:0]        on_cnt_q, on_cnt_d;
    logic [7:0]        dead_cnt_q, dead_cnt_d;
    logic [7:0]        fan_q, fan_d;
    logic              heat_q, heat_d;
    logic signed [8:0] err_q, err_d;
    logic [7:0]        chs_conf_q, chs_conf_d;
    logic [7:0]        speed_q, speed_d;
    logic              heat_req_q, heat_req_d;
    logic              busy_q, busy_d;
    logic [2:0]        state_o_q, state_o_d;

    chs_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .arst (arst),
        .tick (tick)
    );

    // next-state, counter, ramp and output-stage logic
    always_comb begin
        err        = 9'(setpoint) - 9'(temp_in);
        fan_sum    = 9'(fan_q) + 9'(FAN_STEP);
        fan_up     = fan_sum > 9'(FAN_MAX) ? 8'(FAN_MAX) : fan_sum[7:0];
        fan_dn     = fan_q > 8'(FAN_STEP) ? fan_q - 8'(FAN_STEP) : 8'd0;
        dead_nx    = dead_cnt_q + 8'd1;
        crossed    = st_q == ST_HEAT ? (err[8] || err == 9'd0) : !err[8];
        st_d       = st_q;
        on_cnt_d   = on_cnt_q;
        dead_cnt_d = dead_cnt_q;
        fan_d      = fan_q;
        heat_d     = heat_q;
        err_d      = tick ? err : err_q;
        case (st_q)
            ST_IDLE: begin
                if (tick && enable && err > HYST_S) begin
                    st_d     = ST_HEAT;
                    heat_d   = 1'b1;
                    on_cnt_d = 8'd0;
                end else if (tick && enable && err < -HYST_S) begin
                    st_d     = ST_COOL;
                    heat_d   = 1'b0;
                    on_cnt_d = 8'd0;
                end
            end
            ST_HEAT, ST_COOL: begin
                if (!enable) begin
                    st_d = ST_RAMPDN;
                end else if (tick) begin
                    if (on_cnt_q >= 8'(MIN_ON) && crossed) begin
                        st_d = ST_RAMPDN;
                    end else begin
                        on_cnt_d = on_cnt_q == 8'hFF ? on_cnt_q : on_cnt_q + 8'd1;
                        fan_d    = fan_up;
                    end
                end
            end
            ST_RAMPDN: begin
                if (tick) begin
                    fan_d = fan_dn;
                    if (fan_dn == 8'd0) begin
                        st_d       = ST_DEAD;
                        dead_cnt_d = 8'd0;
                        heat_d     = 1'b0;
                    end
                end
            end
            ST_DEAD: begin
                if (tick) begin
                    dead_cnt_d = dead_nx;
                    st_d       = dead_nx == 8'(DEAD) ? ST_IDLE : ST_DEAD;
                end
            end
            default: st_d = ST_IDLE;
        endcase
        chs_conf_d = (st_q == ST_HEAT || st_q == ST_COOL || st_q == ST_RAMPDN) ? sat_conf(err_q) : 8'd0;
        speed_d    = fan_q;
        heat_req_d = heat_q;
        busy_d     = st_q != ST_IDLE;
        state_o_d  = st_q;
    end

    // session state and the registered output stage behind it
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            st_q       <= ST_IDLE;
            on_cnt_q   <= 8'd0;
            dead_cnt_q <= 8'd0;
            fan_q      <= 8'd0;
            heat_q     <= 1'b0;
            err_q      <= 9'sd0;
            chs_conf_q <= 8'd0;
            speed_q    <= 8'd0;
            heat_req_q <= 1'b0;
            busy_q     <= 1'b0;
            state_o_q  <= 3'd0;
        end else begin
            st_q       <= st_d;
            on_cnt_q   <= on_cnt_d;
            dead_cnt_q <= dead_cnt_d;
            fan_q      <= fan_d;
            heat_q     <= heat_d;
            err_q      <= err_d;
            chs_conf_q <= chs_conf_d;
            speed_q    <= speed_d;
            heat_req_q <= heat_req_d;
            busy_q     <= busy_d;
            state_o_q  <= state_o_d;
        end
    end

    assign chs_conf = chs_conf_q;
    assign speed    = speed_q;
    assign heat_req = heat_req_q;
    assign busy     = busy_q;
    assign state_o  = state_o_q;

endmodule

// File: tb/tb_chs_sequencer.sv
// tb_chs_sequencer: directed scenarios plus random stimulus against a behavioural thermostat model
module tb_chs_sequencer;

    localparam int TD = 4, HY = 2, MO = 4, DT = 3, FS = 64, FM = 255;

    logic       clk = 1'b0;
    logic       arst = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] temp_in = 8'd0;
    logic [7:0] setpoint = 8'd0;
    logic [7:0] chs_conf, speed;
    logic       heat_req, busy;
    logic [2:0] state_o;

    chs_sequencer #(
        .TICK_DIV(TD), .HYST(HY), .MIN_ON(MO), .DEAD(DT), .FAN_STEP(FS), .FAN_MAX(FM)
    ) dut (
        .clk      (clk),
        .arst     (arst),
        .enable   (enable),
        .temp_in  (temp_in),
        .setpoint (setpoint),
        .chs_conf (chs_conf),
        .speed    (speed),
        .heat_req (heat_req),
        .busy     (busy),
        .state_o  (state_o)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    // model: 0 idle, 1 heat, 2 cool, 3 ramp-down, 4 dead
    int phase, mode, on, dead, fan, heat, err;
    int e_st, e_conf, e_spd, e_hr, e_busy;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        phase = 0; mode = 0; on = 0; dead = 0; fan = 0; heat = 0; err = 0;
        e_st = 0; e_conf = 0; e_spd = 0; e_hr = 0; e_busy = 0;
    endtask

    // one clock of the thermostat rules; visible outputs trail the session by one clock
    task automatic m_step();
        bit tk;
        int e;
        tk = phase == TD - 1;
        e = int'(setpoint) - int'(temp_in);
        phase = (phase + 1) % TD;
        e_st = mode;
        e_spd = fan;
        e_hr = heat;
        e_busy = mode != 0 ? 1 : 0;
        e_conf = (mode >= 1 && mode <= 3) ? ((err > 127 ? 127 : err < -128 ? -128 : err) & 255) : 0;
        if (tk) err = e;
        if ((mode == 1 || mode == 2) && !enable) mode = 3;
        else if (tk) begin
            if (mode == 0) begin
                if (enable && e > HY) begin mode = 1; heat = 1; on = 0; end
                else if (enable && e < -HY) begin mode = 2; heat = 0; on = 0; end
            end else if (mode == 1 || mode == 2) begin
                if (on >= MO && (mode == 1 ? e <= 0 : e >= 0)) mode = 3;
                else begin
                    on = on < 255 ? on + 1 : 255;
                    fan = fan + FS > FM ? FM : fan + FS;
                end
            end else if (mode == 3) begin
                fan = fan > FS ? fan - FS : 0;
                if (fan == 0) begin mode = 4; dead = 0; heat = 0; end
            end else begin
                dead++;
                if (dead == DT) mode = 0;
            end
        end
    endtask

    task automatic cmp_all();
        check("state", int'(state_o), e_st);
        check("conf", int'(chs_conf), e_conf);
        check("speed", int'(speed), e_spd);
        check("heat_req", int'(heat_req), e_hr);
        check("busy", int'(busy), e_busy);
    endtask

    task automatic cyc();
        @(posedge clk);
        m_step();
        @(negedge clk);
        cmp_all();
    endtask

    task automatic do_reset();
        arst = 1'b0;
        #1;
        m_reset();
        cmp_all();
        @(negedge clk);
        arst = 1'b1;
    endtask

    task automatic wait_st(input int s, input int budget);
        int n;
        n = 0;
        while (e_st != s && n < budget) begin
            cyc();
            n++;
        end
        check($sformatf("reach_state_%0d", s), int'(state_o), s);
    endtask

    int exp_st[10] = '{1, 1, 3, 3, 3, 3, 4, 4, 4, 0};
    int exp_sp[10] = '{192, 255, 255, 191, 127, 63, 0, 0, 0, 0};

    initial begin
        do_reset();
        setpoint = 8'd25; temp_in = 8'd20; enable = 1'b1;
        wait_st(1, 20);
        check("heat_conf", int'(chs_conf), 5);
        check("heat_req_on", int'(heat_req), 1);
        repeat (TD) cyc();
        check("ramp_64", int'(speed), 64);
        repeat (TD) cyc();
        check("ramp_128", int'(speed), 128);
        temp_in = 8'd26;
        for (int i = 0; i < 10; i++) begin
            repeat (TD) cyc();
            check($sformatf("minon_state_%0d", i), int'(state_o), exp_st[i]);
            check($sformatf("minon_speed_%0d", i), int'(speed), exp_sp[i]);
        end
        temp_in = 8'd23;
        repeat (3 * TD) cyc();
        check("hyst_idle", int'(state_o), 0);
        temp_in = 8'd22;
        wait_st(1, 20);
        check("hyst_conf", int'(chs_conf), 3);
        temp_in = 8'd25;
        wait_st(4, 200);
        temp_in = 8'd40;
        repeat (2 * TD) cyc();
        check("dead_hold", int'(state_o), 4);
        repeat (TD) cyc();
        check("dead_done", int'(state_o), 0);
        repeat (TD) cyc();
        check("rev_cool", int'(state_o), 2);
        check("rev_conf", int'(chs_conf), 8'hF1);
        check("rev_heat_req", int'(heat_req), 0);
        repeat (TD) cyc();
        enable = 1'b0;
        cyc();
        cyc();
        check("abort_rampdn", int'(state_o), 3);
        check("abort_busy", int'(busy), 1);
        wait_st(0, 100);
        check("abort_idle_busy", int'(busy), 0);
        enable = 1'b1; setpoint = 8'd200; temp_in = 8'd10;
        wait_st(1, 20);
        check("sat_pos", int'(chs_conf), 127);
        repeat (3 * TD) cyc();
        check("pre_rst_speed", int'(speed), 192);
        do_reset();
        check("rst_speed", int'(speed), 0);
        check("rst_state", int'(state_o), 0);
        check("rst_busy", int'(busy), 0);
        setpoint = 8'd0; temp_in = 8'd250;
        wait_st(2, 20);
        check("sat_neg", int'(chs_conf), 128);
        repeat (3000) begin
            if ($urandom_range(0, 63) == 0) setpoint = 8'($urandom_range(10, 40));
            if ($urandom_range(0, 15) == 0)
                temp_in = $urandom_range(0, 15) == 0 ? 8'($urandom_range(0, 255))
                                                     : 8'(int'(setpoint) + int'($urandom_range(0, 12)) - 6);
            enable = $urandom_range(0, 99) >= 3;
            if ($urandom_range(0, 999) == 0) do_reset();
            else cyc();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
